ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue_if.sv | 24 ++
 rtl/ifetch_queue.sv | 95 +++++++++
 tb/tb_ifetch_queue.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch-queue bundle: redirect, instruction-memory port and consumer side.
// The slave modport is the queue; master is whoever drives it.
interface ifetch_queue_if;
   logic        flush;
   logic [14:0] flush_addr;
   logic        imem_rd;
   logic [14:0] imem_addr;
   logic [15:0] imem_data;
   logic        deq_req;
   logic        instr_valid;
   logic [15:0] instr_out;
   logic [14:0] instr_pc;
   logic [2:0]  cnt;

   modport slave (
      input  flush, flush_addr, imem_data, deq_req,
      output imem_rd, imem_addr, instr_valid, instr_out, instr_pc, cnt
   );

   modport master (
      output flush, flush_addr, imem_data, deq_req,
      input  imem_rd, imem_addr, instr_valid, instr_out, instr_pc, cnt
   );
endinterface

// File: rtl/ifetch_queue.sv
// Four-entry instruction prefetch queue with single-cycle-latency memory port.
// Reads are only issued when the returning word is guaranteed a free slot.
module ifetch_queue #(
   parameter logic [14:0] RESET_PC = 15'h0000
) (
   input logic            clk,
   input logic            rst,
   ifetch_queue_if.slave  bus_io
);

   logic [14:0] pc_q    [4];
   logic [15:0] instr_q [4];
   logic [1:0]  head_q, head_d, tail_q, tail_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [14:0] fetch_pc_q, fetch_pc_d;
   logic [14:0] req_pc_q, req_pc_d;
   logic        inflight_q, inflight_d;

   logic [3:0]  occ;
   logic        rd, wr, pop;
   logic        unused_flush_addr_lsb;

   assign unused_flush_addr_lsb = bus_io.flush_addr[0];

   // Occupancy counts the outstanding read so the return always has a slot.
   assign occ = {1'b0, cnt_q} + {3'b000, inflight_q};
   assign rd  = rst && !bus_io.flush && (occ < 4'd4);
   assign wr  = inflight_q && !bus_io.flush;
   assign pop = bus_io.deq_req && (cnt_q != 3'd0) && !bus_io.flush;

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      cnt_d      = cnt_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = rd;
      if (bus_io.flush) begin
         head_d     = 2'd0;
         tail_d     = 2'd0;
         cnt_d      = 3'd0;
         fetch_pc_d = {bus_io.flush_addr[14:1], 1'b0};
      end else begin
         if (rd) begin
            fetch_pc_d = fetch_pc_q + 15'd2;
            req_pc_d   = fetch_pc_q;
         end
         if (wr) tail_d = tail_q + 2'd1;
         if (pop) head_d = head_q + 2'd1;
         unique case ({wr, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q     <= 2'd0;
         tail_q     <= 2'd0;
         cnt_q      <= 3'd0;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         inflight_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         cnt_q      <= cnt_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            pc_q[i]    <= 15'd0;
            instr_q[i] <= 16'd0;
         end
      end else if (wr) begin
         pc_q[tail_q]    <= req_pc_q;
         instr_q[tail_q] <= bus_io.imem_data;
      end
   end

   assign bus_io.imem_rd     = rd;
   assign bus_io.imem_addr   = fetch_pc_q;
   assign bus_io.cnt         = cnt_q;
   assign bus_io.instr_valid = (cnt_q != 3'd0);
   assign bus_io.instr_out   = (cnt_q != 3'd0) ? instr_q[head_q] : 16'd0;
   assign bus_io.instr_pc    = (cnt_q != 3'd0) ? pc_q[head_q] : 15'd0;

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench: issued reads are queued as expected entries and retired
// when the queue pops them; a second instance exercises address wrap.
module tb_ifetch_queue;

   logic clk = 1'b0;
   logic rst, rst2;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   ifetch_queue_if q1 ();
   ifetch_queue_if q2 ();

   ifetch_queue #(.RESET_PC(15'h0000)) dut1 (.clk(clk), .rst(rst),  .bus_io(q1));
   ifetch_queue #(.RESET_PC(15'h7FFC)) dut2 (.clk(clk), .rst(rst2), .bus_io(q2));

   // Memory answers one cycle after the strobe with A000 + address.
   always @(posedge clk) begin
      if (q1.imem_rd) q1.imem_data <= 16'(16'hA000 + {1'b0, q1.imem_addr});
      if (q2.imem_rd) q2.imem_data <= 16'(16'hA000 + {1'b0, q2.imem_addr});
   end

   logic [30:0] exp_q[$];
   logic        pend_v;
   logic [14:0] pend_a;
   logic [14:0] fpc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   // One clock of dut1: compare against the model at negedge, then advance it.
   task automatic tick();
      int   sz;
      logic rd_e;
      @(negedge clk);
      sz = exp_q.size();
      if (!rst) begin
         check("rst_cnt", 32'(q1.cnt), 32'd0);
         check("rst_rd", 32'(q1.imem_rd), 32'd0);
         check("rst_valid", 32'(q1.instr_valid), 32'd0);
         check("rst_out", 32'(q1.instr_out), 32'd0);
         check("rst_pc", 32'(q1.instr_pc), 32'd0);
         check("rst_addr", 32'(q1.imem_addr), 32'd0);
         exp_q.delete();
         pend_v = 1'b0;
         fpc    = 15'h0000;
      end else begin
         rd_e = !q1.flush && ((sz + int'(pend_v)) < 4);
         check("cnt", 32'(q1.cnt), 32'(sz));
         check("valid", 32'(q1.instr_valid), 32'(sz != 0));
         check("head_pc", 32'(q1.instr_pc), (sz != 0) ? 32'(exp_q[0][30:16]) : 32'd0);
         check("head_instr", 32'(q1.instr_out), (sz != 0) ? 32'(exp_q[0][15:0]) : 32'd0);
         check("imem_rd", 32'(q1.imem_rd), 32'(rd_e));
         check("imem_addr", 32'(q1.imem_addr), 32'(fpc));
         if (q1.flush) begin
            exp_q.delete();
            pend_v = 1'b0;
            fpc    = {q1.flush_addr[14:1], 1'b0};
         end else begin
            if (q1.deq_req && sz != 0) void'(exp_q.pop_front());
            if (pend_v) exp_q.push_back({pend_a, 16'(16'hA000 + {1'b0, pend_a})});
            pend_v = rd_e;
            pend_a = fpc;
            if (rd_e) fpc = fpc + 15'd2;
         end
      end
      @(posedge clk);
      #1;
   endtask

   logic [14:0] wrap_a [6];

   initial begin
      wrap_a = '{15'h7FFC, 15'h7FFE, 15'h0000, 15'h0002, 15'h0004, 15'h0006};
      rst = 1'b0; rst2 = 1'b0;
      q1.flush = 1'b0; q1.flush_addr = 15'd0; q1.deq_req = 1'b0;
      q2.flush = 1'b0; q2.flush_addr = 15'd0; q2.deq_req = 1'b1;
      q1.imem_data = 16'd0; q2.imem_data = 16'd0;
      pend_v = 1'b0; pend_a = 15'd0; fpc = 15'd0;
      tick(); tick();
      rst = 1'b1;

      // Fill with no consumer.
      repeat (8) tick();
      check("fill_cnt", 32'(q1.cnt), 32'd4);
      check("fill_head", 32'(q1.instr_out), 32'hA000);

      // Drain every cycle: one instruction per cycle.
      q1.deq_req = 1'b1;
      repeat (12) tick();

      // Redirect to an odd address with a read outstanding.
      q1.flush = 1'b1; q1.flush_addr = 15'h0101;
      tick();
      q1.flush = 1'b0; q1.deq_req = 1'b0;
      check("post_flush_addr", 32'(q1.imem_addr), 32'h0100);
      tick(); tick();
      check("flush_valid", 32'(q1.instr_valid), 32'd1);
      check("flush_pc", 32'(q1.instr_pc), 32'h0100);

      // Consumer pops while empty, then concurrently with the first write.
      q1.flush = 1'b1; q1.flush_addr = 15'h0200;
      tick();
      q1.flush = 1'b0; q1.deq_req = 1'b1;
      repeat (4) tick();

      // Build cnt=3 with a read in flight, then reset asynchronously.
      q1.deq_req = 1'b0;
      repeat (6) tick();
      q1.deq_req = 1'b1;
      tick();
      q1.deq_req = 1'b0;
      tick();
      check("pre_rst_cnt", 32'(q1.cnt), 32'd3);
      rst = 1'b0;
      #1;
      check("async_cnt", 32'(q1.cnt), 32'd0);
      check("async_valid", 32'(q1.instr_valid), 32'd0);
      check("async_rd", 32'(q1.imem_rd), 32'd0);
      tick();
      rst = 1'b1;
      check("rel_addr", 32'(q1.imem_addr), 32'h0000);
      repeat (6) tick();

      // Wrap across the top of the address space.
      rst2 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i < 4) check("wrap_addr", 32'(q2.imem_addr), 32'(wrap_a[i]));
         if (i >= 2) check("wrap_pc", 32'(q2.instr_pc), 32'(wrap_a[i-2]));
         @(posedge clk);
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
